// File: rtl/decode_stage.sv
// RISC-V decode pipeline stage: registered decode with a main/skid output buffer.
// Decodes fields, immediate, register-usage and illegal flags.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic            out_illegal
);

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_OP_IMM   = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_OP_IMM32 = 7'b0011011,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_OP32     = 7'b0111011,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    entry_t      dec;
    entry_t      main_q;
    entry_t      skid_q;
    logic        main_v;
    logic        skid_v;
    logic        ready_q;
    logic [31:0] imm32;
    logic        legal;
    logic [2:0]  f3;
    logic        in_fire;
    logic        out_fire;
    logic        drain;
    logic        main_v_n;
    logic        skid_v_n;

    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        dec.inst = in_inst;
        f3       = in_inst[14:12];
        imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
        case (in_inst[6:0])
            OP_STORE:  imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            OP_BRANCH: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0};
            OP_JAL:    imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {in_inst[31:12], 12'b0};
            default: ;
        endcase
        dec.imm        = {XLEN{imm32[31]}};
        dec.imm[31:0]  = imm32;

        case (in_inst[6:0])
            OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: legal = 1'b1;
            OP_OP_IMM32, OP_OP32: legal = (XLEN == 64);
            default: legal = 1'b0;
        endcase
        if (in_inst[1:0] != 2'b11) legal = 1'b0;

        case (in_inst[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: dec.rs1_used = 1'b0;
            OP_SYSTEM: dec.rs1_used = (f3 != 3'd0) && !f3[2];
            default:   dec.rs1_used = 1'b1;
        endcase
        case (in_inst[6:0])
            OP_STORE, OP_BRANCH, OP_OP, OP_OP32: dec.rs2_used = 1'b1;
            default: dec.rs2_used = 1'b0;
        endcase
        case (in_inst[6:0])
            OP_STORE, OP_BRANCH, OP_MISC_MEM: dec.rd_we = 1'b0;
            OP_SYSTEM: dec.rd_we = (f3 != 3'd0);
            default:   dec.rd_we = 1'b1;
        endcase
        if (in_inst[11:7] == 5'd0) dec.rd_we = 1'b0;

        dec.illegal = !legal;
        if (!legal) begin
            dec.rd_we    = 1'b0;
            dec.rs1_used = 1'b0;
            dec.rs2_used = 1'b0;
        end
    end

    // skid can only hold data while main is full and in_ready is low,
    // so a drain with skid valid never coincides with an input transfer
    always_comb begin
        in_fire  = in_valid && ready_q && !flush;
        out_fire = main_v && out_ready && !flush;
        drain    = !main_v || out_fire;
        main_v_n = drain ? (skid_v || in_fire) : 1'b1;
        skid_v_n = drain ? 1'b0 : (skid_v || in_fire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            main_v  <= main_v_n;
            skid_v  <= skid_v_n;
            ready_q <= !skid_v_n;
            if (drain) begin
                if (skid_v)       main_q <= skid_q;
                else if (in_fire) main_q <= dec;
            end else if (in_fire) begin
                skid_q <= dec;
            end
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = main_v;
    assign out_pc       = main_q.pc;
    assign out_inst     = main_q.inst;
    assign out_imm      = main_q.imm;
    assign out_opcode   = main_q.inst[6:0];
    assign out_rd       = main_q.inst[11:7];
    assign out_funct3   = main_q.inst[14:12];
    assign out_rs1      = main_q.inst[19:15];
    assign out_rs2      = main_q.inst[24:20];
    assign out_funct7   = main_q.inst[31:25];
    assign out_rs1_used = main_q.rs1_used;
    assign out_rs2_used = main_q.rs2_used;
    assign out_rd_we    = main_q.rd_we;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: XLEN=32 and XLEN=64 instances share stimulus;
// expected entries are queued on input transfer and checked by a monitor on output transfer.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_inst;

    logic        in_ready, out_valid, rs1u, rs2u, rdwe, ill;
    logic [31:0] out_pc, out_inst, out_imm;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;

    logic        in_ready64, out_valid64, rs1u64, rs2u64, rdwe64, ill64;
    logic [31:0] out_pc64, out_inst64;
    logic [63:0] out_imm64;
    logic [6:0]  opc64, f764;
    logic [4:0]  rd64, rs164, rs264;
    logic [2:0]  f364;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [63:0] imm;
        logic [3:0]  f32;
        logic [3:0]  f64;
    } exp_t;

    exp_t vec[14];
    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic [31:0] pc_ctr = 32'h1000;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_imm(out_imm), .out_opcode(opc), .out_rd(rd), .out_funct3(f3),
        .out_rs1(rs1), .out_rs2(rs2), .out_funct7(f7),
        .out_rs1_used(rs1u), .out_rs2_used(rs2u), .out_rd_we(rdwe), .out_illegal(ill)
    );

    decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64), .out_inst(out_inst64),
        .out_imm(out_imm64), .out_opcode(opc64), .out_rd(rd64), .out_funct3(f364),
        .out_rs1(rs164), .out_rs2(rs264), .out_funct7(f764),
        .out_rs1_used(rs1u64), .out_rs2_used(rs2u64), .out_rd_we(rdwe64), .out_illegal(ill64)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // flags packed as {rs1_used, rs2_used, rd_we, illegal}
    function automatic exp_t mk(logic [31:0] inst, logic [63:0] imm, logic [3:0] a, logic [3:0] b);
        exp_t e;
        e.pc = '0; e.inst = inst; e.imm = imm; e.f32 = a; e.f64 = b;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            chk("valid64_match", {63'd0, out_valid64}, 64'd1);
            if (q.size() == 0) begin
                chk("unexpected_output", {32'd0, out_inst}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pc",     {32'd0, out_pc}, {32'd0, e.pc});
                chk("inst",   {32'd0, out_inst}, {32'd0, e.inst});
                chk("fields", {21'd0, f7, rs2, rs1, f3, rd, opc}, {21'd0, e.inst[31:25],
                    e.inst[24:20], e.inst[19:15], e.inst[14:12], e.inst[11:7], e.inst[6:0]});
                chk("imm32",  {32'd0, out_imm}, {32'd0, e.imm[31:0]});
                chk("flags32", {60'd0, rs1u, rs2u, rdwe, ill}, {60'd0, e.f32});
                chk("pc64",   {32'd0, out_pc64}, {32'd0, e.pc});
                chk("inst64", {32'd0, out_inst64}, {32'd0, e.inst});
                chk("fields64", {21'd0, f764, rs264, rs164, f364, rd64, opc64}, {21'd0, e.inst[31:25],
                    e.inst[24:20], e.inst[19:15], e.inst[14:12], e.inst[11:7], e.inst[6:0]});
                chk("imm64",  out_imm64, e.imm);
                chk("flags64", {60'd0, rs1u64, rs2u64, rdwe64, ill64}, {60'd0, e.f64});
            end
        end
    end

    task automatic send(input exp_t e_in);
        exp_t e;
        bit ok;
        e = e_in;
        e.pc = pc_ctr;
        pc_ctr += 4;
        in_valid = 1'b1; in_pc = e.pc; in_inst = e.inst;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                ok = 1;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, {62'd0, out_valid, out_valid64}, 64'd0);
        chk({tag, "_ready"}, {62'd0, in_ready, in_ready64}, 64'd0);
        chk({tag, "_data"}, {out_pc, out_inst}, 64'd0);
        chk({tag, "_imm"}, out_imm64 | {32'd0, out_imm}, 64'd0);
        chk({tag, "_flags"}, {56'd0, rs1u, rs2u, rdwe, ill, rs1u64, rs2u64, rdwe64, ill64}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = mk(32'h00512423, 64'h8,                  4'b1100, 4'b1100); // sw x5,8(x2)
        vec[1]  = mk(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC,   4'b1100, 4'b1100); // beq -4
        vec[2]  = mk(32'h123450B7, 64'h12345000,           4'b0010, 4'b0010); // lui x1
        vec[3]  = mk(32'h800000B7, 64'hFFFFFFFF80000000,   4'b0010, 4'b0010);
        vec[4]  = mk(32'h00000000, 64'h0,                  4'b0001, 4'b0001);
        vec[5]  = mk(32'h00000013, 64'h0,                  4'b1000, 4'b1000); // addi x0
        vec[6]  = mk(32'h002080BB, 64'h2,                  4'b0001, 4'b1110); // addw, RV64 only
        vec[7]  = mk(32'h008000EF, 64'h8,                  4'b0010, 4'b0010); // jal x1,8
        vec[8]  = mk(32'h3000A2F3, 64'h300,                4'b1010, 4'b1010); // csrrs
        vec[9]  = mk(32'h3001D2F3, 64'h300,                4'b0010, 4'b0010); // csrrwi
        vec[10] = mk(32'h00000073, 64'h0,                  4'b0000, 4'b0000); // ecall
        vec[11] = mk(32'hFE512E23, 64'hFFFFFFFFFFFFFFFC,   4'b1100, 4'b1100); // sw -4
        vec[12] = mk(32'h00100092, 64'h1,                  4'b0001, 4'b0001); // inst[1:0]=10
        vec[13] = mk(32'hFF80A183, 64'hFFFFFFFFFFFFFFF8,   4'b1010, 4'b1010); // lw x3,-8(x1)

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_inst = '0;
        repeat (2) @(posedge clk); #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {62'd0, in_ready, in_ready64}, 64'd3);
        chk("valid_after_reset", {63'd0, out_valid}, 64'd0);

        foreach (vec[i]) send(vec[i]);
        drain();

        // back-pressure: A in main, B in skid, C held until space frees
        out_ready = 1'b0;
        send(vec[2]);
        chk("bp_a_valid", {63'd0, out_valid}, 64'd1);
        send(vec[7]);
        chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
        fork
            send(vec[8]);
            begin
                repeat (3) @(posedge clk); #1;
                chk("bp_hold_inst", {32'd0, out_inst}, {32'd0, vec[2].inst});
                chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // flush with main and skid full, input offered in the flush cycle
        out_ready = 1'b0;
        send(vec[0]);
        send(vec[1]);
        chk("fl_full_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000013;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("fl_valid", {62'd0, out_valid, out_valid64}, 64'd0);
        chk("fl_ready", {62'd0, in_ready, in_ready64}, 64'd3);
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("fl_no_output", {63'd0, out_valid}, 64'd0);

        // flush with in_ready high: input and output transfers both discarded
        out_ready = 1'b0;
        send(vec[5]);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h123450B7; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        repeat (3) @(posedge clk); #1;
        chk("fl2_no_output", {63'd0, out_valid}, 64'd0);

        // reset mid-stream with buffered entries
        out_ready = 1'b0;
        send(vec[13]);
        send(vec[3]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("midreset");
        rst_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
        chk("midreset_ready", {63'd0, in_ready}, 64'd1);
        chk("midreset_valid", {63'd0, out_valid}, 64'd0);

        out_ready = 1'b1;
        send(vec[9]);
        send(vec[11]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RISC-V decode pipeline stage between fetch and execute.
- Accepts {pc, instruction} over a valid/ready handshake.
- Emits decoded fields, an XLEN-wide sign-extended immediate for all base formats (I/S/B/U/J), and register-usage and illegal-opcode flags.
- A two-entry output buffer (main + skid) gives full throughput under back-pressure; `flush` discards in-flight entries on a redirect.

Parameters:
- XLEN, 32, data/immediate width; legal values 32 or 64.
- PC_W, 32, width of the pc field carried through.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all buffered entries
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept
- in_pc  in  PC_W  instruction address
- in_inst  in  32  raw instruction word
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts entry
- out_pc  out  PC_W  pc of entry
- out_inst  out  32  raw word of entry
- out_imm  out  XLEN  sign-extended immediate
- out_opcode  out  7  inst[6:0]
- out_rd  out  5  inst[11:7]
- out_funct3  out  3  inst[14:12]
- out_rs1  out  5  inst[19:15]
- out_rs2  out  5  inst[24:20]
- out_funct7  out  7  inst[31:25]
- out_rs1_used  out  1  rs1 is a true source
- out_rs2_used  out  1  rs2 is a true source
- out_rd_we  out  1  writes rd (rd != 0)
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst_n=0 at edge):
  - main and skid entries invalid; all out_* registers 0.
  - in_ready=0 while rst_n=0; in_ready=1 the first cycle after release.
- Decode is combinational on in_inst and captured with the entry. Latency is 1 cycle: accepted at edge N, visible at out_* after edge N.
- Immediate formats, sign bit inst[31] replicated to XLEN:
  - S (0100011): {inst[31:25], inst[11:7]}
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - U (0110111 LUI, 0010111 AUIPC): {inst[31:12], 12'b0}
  - all other opcodes: I-type {inst[31:20]}
- Legal opcodes: 0000011, 0001111, 0010011, 0010111, 0011011 (XLEN=64 only), 0100011, 0110011, 0110111, 0111011 (XLEN=64 only), 1100011, 1100111, 1101111, 1110011.
  - Any other opcode, or inst[1:0] != 2'b11, sets illegal=1.
  - An illegal entry forces rd_we=0, rs1_used=0, rs2_used=0. The immediate is still computed.
- rs1_used = 0 for LUI, AUIPC, JAL. For SYSTEM: rs1_used = (funct3 != 0 && !funct3[2]). Otherwise 1.
- rs2_used = 1 only for STORE, BRANCH, OP (0110011/0111011).
- rd_we:
  - 0 for STORE, BRANCH, MISC_MEM.
  - SYSTEM: rd_we = (funct3 != 0).
  - All other legal opcodes: rd_we = 1.
  - Always 0 when rd == 0.
- Handshake:
  - Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
  - in_ready is registered and equals !skid_valid.
  - Main entry drives out_*. Input goes to main if main is empty or being drained this cycle, otherwise to skid.
  - On drain: skid moves to main when skid is valid, else main takes the new input or becomes invalid.
  - Order preserved; no entry duplicated or lost.
- out_* hold stable while out_valid && !out_ready.
- flush (rst_n=1):
  - At the edge, main and skid become invalid and out_valid=0 next cycle; in_ready=1 next cycle.
  - Any input or output transfer in the flush cycle is discarded: the input is not stored, and the output counts as not taken.
- Reset dominates flush.
- When out_valid=0, out_* data keep their last value (don't-care for consumers).

Test Plan:
- Single issue: in_inst=0x00512423 (sw x5,8(x2)), out_ready=1 -> next cycle out_valid=1, imm=0x8, rs1=2, rs2=5, rs1_used=1, rs2_used=1, rd_we=0, illegal=0.
- Immediates:
  - 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC.
  - 0x123450B7 (lui x1) -> imm=0x12345000, rd_we=1, rs1_used=0.
  - With XLEN=64, 0x800000B7 -> imm=0xFFFFFFFF80000000.
- Back-pressure: out_ready=0, three back-to-back in_valid (A, B, C) -> A in main, B in skid, in_ready=0 on C's cycle and C is held. Then out_ready=1 -> A, B, C emerge on consecutive cycles in order.
- Illegal and x0: 0x00000000 -> illegal=1, rd_we=0. 0x00000013 (addi x0,x0,0) -> illegal=0, rd_we=0.
- Flush: with main and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and that cycle's input never appears.
- Reset mid-stream: hold rst_n=0 one cycle with entries buffered -> out_valid=0, all out_*=0, in_ready=0 during reset, 1 after.
